// File: rtl/mips_avalon_pkg.sv
// Shared types and constants for the Avalon-MM slave RAM.
//   state_t           : transfer FSM state (IDLE, WAIT)
//   AVALON_WORD_W     : data bus width
//   AVALON_BE_W       : byteenable width
//   MIPS_RESET_VECTOR : default byte address mapped to RAM word 0
package mips_avalon_pkg;
  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  localparam int          AVALON_WORD_W     = 32;
  localparam int          AVALON_BE_W       = 4;
  localparam logic [31:0] MIPS_RESET_VECTOR = 32'hBFC00000;
endpackage

// File: rtl/mips_avalon_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11), one step per cycle with en high.
// Ports:
//   clk   in   clock, rising edge
//   rst   in   synchronous active-high reset, loads SEED
//   en    in   advance one step
//   value out  current LFSR state
module mips_avalon_lfsr #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [15:0] value
);
  always_ff @(posedge clk) begin
    if (rst)     value <= SEED;
    else if (en) value <= {value[14:0], value[15] ^ value[13] ^ value[12] ^ value[10]};
  end
endmodule

// File: rtl/mips_avalon_slave_ram.sv
// Avalon-MM slave word RAM with wait-state insertion, byte-lane writes and a
// sticky master protocol-violation flag.
// Build option: AVALON_RAM_RANDOM_WAIT_EN selects LFSR-driven wait states
// (1..MAX_WAIT per transfer) instead of the fixed WAIT_CYCLES.
// Ports:
//   clk, rst        clock / synchronous active-high reset
//   address         byte address, bits[1:0] ignored
//   read, write     requests, held by the master until waitrequest is low
//   writedata       write data
//   byteenable      per-byte write lane enables
//   waitrequest     1 = request not yet accepted
//   readdata        valid while read=1 and waitrequest=0
//   protocol_error  sticky violation flag, cleared only by rst
module mips_avalon_slave_ram
  import mips_avalon_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = MIPS_RESET_VECTOR,
  parameter int          DEPTH_WORDS = 4096,
`ifdef AVALON_RAM_RANDOM_WAIT_EN
  parameter int          MAX_WAIT    = 8,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
`else
  parameter int          WAIT_CYCLES = 2,
`endif
  parameter string       INIT_FILE   = ""
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              address,
  input  logic                     read,
  input  logic                     write,
  input  logic [AVALON_WORD_W-1:0] writedata,
  input  logic [AVALON_BE_W-1:0]   byteenable,
  output logic                     waitrequest,
  output logic [AVALON_WORD_W-1:0] readdata,
  output logic                     protocol_error
);
  localparam int AW = $clog2(DEPTH_WORDS);

  logic [AVALON_WORD_W-1:0] mem [DEPTH_WORDS];

  state_t                   state;
  logic [3:0]               cnt, wait_target, next_target;
  logic [31:0]              lat_addr;
  logic                     lat_rd, lat_wr;
  logic [AVALON_WORD_W-1:0] lat_wd;
  logic [AVALON_BE_W-1:0]   lat_be;
  logic                     holding, done, changed, viol, start, commit;

  function automatic logic hit(input logic [31:0] a);
    return (a >= BASE_ADDR) && (((a - BASE_ADDR) >> 2) < 32'(DEPTH_WORDS));
  endfunction

  function automatic logic [AW-1:0] widx(input logic [31:0] a);
    return AW'((a - BASE_ADDR) >> 2);
  endfunction

`ifdef AVALON_RAM_RANDOM_WAIT_EN
  logic [15:0] lfsr;
  mips_avalon_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .en    (start),
    .value (lfsr)
  );
  assign next_target = 4'(16'd1 + (lfsr % 16'(MAX_WAIT)));
`else
  assign next_target = 4'(WAIT_CYCLES);
`endif

  always_comb begin
    holding = (state == WAIT) && (cnt != wait_target);
    done    = (state == WAIT) && (cnt == wait_target);
    // Any drift of the held request, including a dropped read/write, counts.
    changed = (address != lat_addr) || (read != lat_rd) || (write != lat_wr) ||
              (writedata != lat_wd) || (byteenable != lat_be);
    viol    = (read && write) || (holding && changed);
    start   = (state == IDLE) && (read || write) && !viol;
    commit  = !rst && done && !viol && lat_wr && hit(lat_addr);
  end

  assign waitrequest = rst || !done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      wait_target    <= '0;
      readdata       <= '0;
      protocol_error <= 1'b0;
      lat_addr       <= '0;
      lat_rd         <= 1'b0;
      lat_wr         <= 1'b0;
      lat_wd         <= '0;
      lat_be         <= '0;
    end else begin
      if (viol) protocol_error <= 1'b1;
      if (state == IDLE) begin
        if (start) begin
          state       <= WAIT;
          cnt         <= 4'd1;
          wait_target <= next_target;
          lat_addr    <= address;
          lat_rd      <= read;
          lat_wr      <= write;
          lat_wd      <= writedata;
          lat_be      <= byteenable;
          // Loading here as well keeps readdata correct when wait_target is 1.
          readdata    <= hit(address) ? mem[widx(address)] : '0;
        end
      end else begin
        readdata <= hit(lat_addr) ? mem[widx(lat_addr)] : '0;
        if (viol || done) begin
          state <= IDLE;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 4'd1;
        end
      end
    end
  end

  // RAM contents are not reset.
  always_ff @(posedge clk) begin
    if (commit)
      for (int i = 0; i < AVALON_BE_W; i++)
        if (lat_be[i]) mem[widx(lat_addr)][8*i +: 8] <= lat_wd[8*i +: 8];
  end
endmodule
